// File: rtl/nand_pair_sweeper_pkg.sv
// Shared definitions for the two-input datapath sweeper: golden op codes,
// sweeper state encoding and the vector count.
package nand_pair_sweeper_pkg;

  // Golden function select, latched from op_sel when a sweep is accepted.
  localparam logic [1:0] OP_NAND = 2'd0;
  localparam logic [1:0] OP_NOR  = 2'd1;
  localparam logic [1:0] OP_AND  = 2'd2;
  localparam logic [1:0] OP_OR   = 2'd3;

  // Number of {x,y} input combinations a sweep covers.
  localparam int NUM_VECTORS = 4;

  // Sweeper states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage : nand_pair_sweeper_pkg

// File: rtl/logic_golden.sv
// Reference truth table for the two-input datapath: returns the expected
// output for the selected operation on the current {x,y} vector.
module logic_golden
  import nand_pair_sweeper_pkg::*;
(
  input  logic [1:0] op,
  input  logic       x,
  input  logic       y,
  output logic       g
);

  // Select the golden output for the requested operation.
  always_comb begin
    g = 1'b0;
    case (op)
      OP_NAND: g = ~(x & y);
      OP_NOR:  g = ~(x | y);
      OP_AND:  g = x & y;
      OP_OR:   g = x | y;
      default: g = 1'b0;
    endcase
  end

endmodule : logic_golden

// File: rtl/nand_pair_sweeper.sv
// Self-checking sequencer for a pair of two-input logic implementations.
// Steps {x,y} through 00,01,10,11, holds each vector SETTLE cycles, samples
// both implementation outputs for one cycle and compares them against each
// other and against the golden function latched at start. Results are held
// until the next accepted start or reset.
module nand_pair_sweeper
  import nand_pair_sweeper_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op_sel,
  input  logic       a,
  input  logic       b,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] mismatch_cnt,
  output logic       fail_seen,
  output logic [1:0] first_fail
);

  // Last value of the settle counter before moving to SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  // Index of the final vector of a sweep.
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

  // Current register state.
  state_t     r_state;
  logic [1:0] r_op;
  logic [1:0] r_vec;
  logic [3:0] r_wait;
  logic       r_x;
  logic       r_y;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_cnt;
  logic       r_fail_seen;
  logic [1:0] r_first_fail;

  // Next-state values.
  state_t     w_state_nxt;
  logic [1:0] w_op_nxt;
  logic [1:0] w_vec_nxt;
  logic [3:0] w_wait_nxt;
  logic       w_x_nxt;
  logic       w_y_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_pass_nxt;
  logic [2:0] w_cnt_nxt;
  logic       w_fail_seen_nxt;
  logic [1:0] w_first_fail_nxt;

  // Comparison helpers.
  logic       w_golden;
  logic       w_fail;
  logic [1:0] w_vec_inc;
  logic [2:0] w_cnt_upd;

  logic_golden u_golden (
    .op (r_op),
    .x  (r_x),
    .y  (r_y),
    .g  (w_golden)
  );

  // A vector fails when the two implementations disagree or the gate-level
  // output disagrees with the golden value; only consumed in SAMPLE.
  always_comb begin
    w_fail    = (a != b) || (a != w_golden);
    w_vec_inc = r_vec + 2'd1;
    w_cnt_upd = r_cnt + {2'b00, w_fail};
  end

  // Next-state and next-output decode for the sweep FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_vec_nxt        = r_vec;
    w_wait_nxt       = r_wait;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_pass_nxt       = r_pass;
    w_cnt_nxt        = r_cnt;
    w_fail_seen_nxt  = r_fail_seen;
    w_first_fail_nxt = r_first_fail;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          // Accept the sweep: latch the golden op and clear prior results.
          w_op_nxt         = op_sel;
          w_cnt_nxt        = 3'd0;
          w_fail_seen_nxt  = 1'b0;
          w_first_fail_nxt = 2'b00;
          w_pass_nxt       = 1'b0;
          w_vec_nxt        = 2'd0;
          w_x_nxt          = 1'b0;
          w_y_nxt          = 1'b0;
          w_wait_nxt       = 4'd0;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = ST_DRIVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        // Hold the vector steady so the datapath settles before sampling.
        if (r_wait == SETTLE_LAST) begin
          w_wait_nxt  = 4'd0;
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_wait_nxt  = r_wait + 4'd1;
          w_state_nxt = ST_DRIVE;
        end
      end

      ST_SAMPLE: begin
        w_cnt_nxt = w_cnt_upd;
        if (w_fail && !r_fail_seen) begin
          w_fail_seen_nxt  = 1'b1;
          w_first_fail_nxt = r_vec;
        end else begin
          w_fail_seen_nxt  = r_fail_seen;
          w_first_fail_nxt = r_first_fail;
        end

        if (r_vec != LAST_VEC) begin
          w_vec_nxt            = w_vec_inc;
          {w_x_nxt, w_y_nxt}   = w_vec_inc;
          w_state_nxt          = ST_DRIVE;
        end else begin
          // Final vector: the verdict includes this cycle's comparison.
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_pass_nxt  = (w_cnt_upd == 3'd0);
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        // One-cycle completion state; start is not sampled here.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_NAND;
      r_vec        <= 2'd0;
      r_wait       <= 4'd0;
      r_x          <= 1'b0;
      r_y          <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_cnt        <= 3'd0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_vec        <= w_vec_nxt;
      r_wait       <= w_wait_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fail_seen  <= w_fail_seen_nxt;
      r_first_fail <= w_first_fail_nxt;
    end
  end

  assign x            = r_x;
  assign y            = r_y;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign mismatch_cnt = r_cnt;
  assign fail_seen    = r_fail_seen;
  assign first_fail   = r_first_fail;

endmodule : nand_pair_sweeper

// File: doc/nand_pair_sweeper.md
Name: nand_pair_sweeper

Overview:
- Self-checking sequencer for the two-input logic datapath pair: a gate-level implementation (output a) and an expression implementation (output b) that share inputs x, y.
- On start, drives all four input vectors in order 00, 01, 10, 11 and waits a settle interval per vector.
- Samples both outputs and compares each against the other and against a golden function chosen by op_sel.
- Reports pass/fail, mismatch count and first failing vector; replaces the hand-written $monitor bench as the reusable checker for this datapath.

Parameters:
- SETTLE, 1, cycles x/y are held before sampling (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- op_sel  input  2  golden function: 0 NAND, 1 NOR, 2 AND, 3 OR; latched at start.
- a  input  1  gate-level DUT output.
- b  input  1  expression DUT output.
- x  output  1  DUT input x, registered.
- y  output  1  DUT input y, registered.
- busy  output  1  high from the accepting edge until DONE is entered.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  held; 1 when last sweep had zero mismatches.
- mismatch_cnt  output  3  held; failing vectors in last sweep (0..4).
- fail_seen  output  1  held; at least one failing vector.
- first_fail  output  2  held; {x,y} of first failing vector, 00 if none.

Behaviour:
- Reset (async, rst_n=0): state IDLE; x=0, y=0, busy=0, done=0, pass=0, mismatch_cnt=0, fail_seen=0, first_fail=00, vec=0, wait counter=0. Reset mid-sweep aborts immediately and discards partial results.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 at edge k latches op_sel.
  - Clears mismatch_cnt, fail_seen, first_fail and pass.
  - Sets vec=0, {x,y}=00, busy=1, and goes to DRIVE.
- DRIVE:
  - Holds {x,y}=vec for SETTLE cycles (wait counter 0..SETTLE-1), then goes to SAMPLE.
- SAMPLE (one cycle):
  - Vector fails if a!=b or a!=golden(op,x,y).
  - On failure: mismatch_cnt+1, and if fail_seen=0 then set fail_seen=1 and first_fail=vec.
  - If vec<3: vec+1, {x,y}=vec+1, go to DRIVE.
  - If vec=3: go to DONE.
- DONE (one cycle): done=1, busy=0, pass=(mismatch_cnt==0 after the final update); then go to IDLE.
- Timing: DONE is entered, and done is high, at edge k+4*(SETTLE+1). SETTLE=1 gives 8 cycles after the accepting edge.
- start while busy or in DONE is ignored with no queuing. start held high re-triggers on the first IDLE cycle after DONE.
- op_sel changes during a sweep have no effect.
- Result outputs hold their values until the next accepted start or reset.
- mismatch_cnt cannot exceed 4, so there is no wrap.
- a and b are sampled only in SAMPLE. Glitches during DRIVE are ignored.

Decomposition:
- Shared package:
  - op codes OP_NAND=0, OP_NOR=1, OP_AND=2, OP_OR=3.
  - state encoding IDLE=0, DRIVE=1, SAMPLE=2, DONE=3.
  - NUM_VECTORS=4.
- One combinational sub-module, logic_golden (op, x, y -> g), holding the truth table. The FSM, counters and result registers stay in nand_pair_sweeper.

Test Plan:
- Both DUTs correct NAND, op_sel=0, SETTLE=1, start pulse at edge k -> x/y step 00,01,10,11; done at k+8; pass=1, mismatch_cnt=0, fail_seen=0, first_fail=00.
- b forced 0, op_sel=0 -> vectors 00,01,10 fail -> mismatch_cnt=3, first_fail=00, pass=0.
- Correct NAND DUTs, op_sel=1 (NOR golden 1,0,0,0) -> 01 and 10 fail -> mismatch_cnt=2, first_fail=01, fail_seen=1.
- op_sel switched 0->3 and start pulsed again during a sweep -> results match the op_sel=0 sweep; single done at k+8; no second sweep.
- rst_n low during SAMPLE of vec 2 -> immediately busy=0, x=y=0, mismatch_cnt=0. Fresh start after release -> full 8-cycle sweep.
- SETTLE=3, correct DUTs -> each vector held 3 cycles; done at k+16; pass=1.
